// File: rtl/stone_drawer_pkg.sv
// Shared game constants: item record layout, screen limits, type codes, colours
// and the drawer's state encoding.
package stone_drawer_pkg;
  localparam int REC_X_LSB    = 23;
  localparam int REC_Y_LSB    = 11;
  localparam int REC_TYPE_LSB = 2;
  localparam int REC_VIS_BIT  = 1;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  localparam logic [1:0] TYPE_STONE = 2'd0;
  localparam logic [1:0] TYPE_GOLD  = 2'd1;

  localparam logic [2:0] COL_STONE_DEF   = 3'b111;
  localparam logic [2:0] COL_GOLD_DEF    = 3'b110;
  localparam logic [2:0] COL_DIAMOND_DEF = 3'b011;
  localparam logic [2:0] COL_BG_DEF      = 3'b000;

  typedef enum logic [3:0] {
    IDLE, E_ADDR, E_WAIT, E_DECIDE, E_PIX,
    D_ADDR, D_WAIT, D_DECIDE, D_PIX, FIN
  } state_t;
endpackage

// File: rtl/stone_drawer_sprite_scan.sv
// Square pixel generator: one registered pixel per cycle from go, row-major,
// with off-screen pixels still taking their cycle but leaving plot low.
module sprite_scan import stone_drawer_pkg::*; #(
  parameter int SPRITE_SIZE = 16,
  parameter int COLOUR_W    = 3
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                go,
  input  logic [8:0]          base_x,
  input  logic [7:0]          base_y,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic                plot,
  output logic [8:0]          x_out,
  output logic [7:0]          y_out,
  output logic [COLOUR_W-1:0] colour,
  output logic                last
);
  localparam int HW = $clog2(SPRITE_SIZE);
  localparam int CW = 2 * HW;

  logic [CW-1:0]       cnt, pix;
  logic                active;
  logic [8:0]          bx, cur_x;
  logic [7:0]          by, cur_y;
  logic [COLOUR_W-1:0] col, cur_col;
  logic [9:0]          x_sum;
  logic [8:0]          y_sum;
  logic                in_bounds;

  // pixel 0 is emitted on the go edge itself so the square has no lead-in gap
  assign pix     = go ? '0 : cnt;
  assign cur_x   = go ? base_x : bx;
  assign cur_y   = go ? base_y : by;
  assign cur_col = go ? colour_in : col;
  assign x_sum   = {1'b0, cur_x} + 10'(pix[HW-1:0]);
  assign y_sum   = {1'b0, cur_y} + 9'(pix[CW-1:HW]);
  assign in_bounds = (x_sum < 10'(SCREEN_W)) && (y_sum < 9'(SCREEN_H));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt <= '0; active <= 1'b0; bx <= '0; by <= '0; col <= '0;
      plot <= 1'b0; x_out <= '0; y_out <= '0; colour <= '0; last <= 1'b0;
    end else begin
      last <= 1'b0;
      if (go) begin
        bx <= base_x; by <= base_y; col <= colour_in;
        cnt <= CW'(1); active <= 1'b1;
      end else if (active) begin
        cnt <= cnt + 1'b1;
        if (cnt == CW'(SPRITE_SIZE * SPRITE_SIZE - 1)) begin
          active <= 1'b0;
          last   <= 1'b1;
        end
      end
      if (go || active) begin
        plot   <= in_bounds;
        x_out  <= x_sum[8:0];
        y_out  <= y_sum[7:0];
        colour <= cur_col;
      end else begin
        plot <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/stone_drawer.sv
// Per-frame item renderer: erases items that moved or vanished using a shadow
// of last-drawn positions, then redraws every visible item as a solid square.
module stone_drawer import stone_drawer_pkg::*; #(
  parameter int                  SPRITE_SIZE  = 16,
  parameter int                  READ_LATENCY = 2,
  parameter int                  COLOUR_W     = 3,
  parameter logic [COLOUR_W-1:0] COL_STONE    = COL_STONE_DEF,
  parameter logic [COLOUR_W-1:0] COL_GOLD     = COL_GOLD_DEF,
  parameter logic [COLOUR_W-1:0] COL_DIAMOND  = COL_DIAMOND_DEF,
  parameter logic [COLOUR_W-1:0] COL_BG       = COL_BG_DEF
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic [3:0]          quantity,
  input  logic [31:0]         ram_data,
  output logic                draw_stone_flag,
  output logic [3:0]          draw_index,
  output logic                plot,
  output logic [8:0]          x_out,
  output logic [7:0]          y_out,
  output logic [COLOUR_W-1:0] colour,
  output logic                busy,
  output logic                done
);
  localparam int WAIT_W = $clog2(READ_LATENCY + 1);

  state_t              state, adv_state;
  logic [3:0]          qty, adv_idx;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [8:0]          rec_x, go_x;
  logic [7:0]          rec_y, go_y;
  logic [1:0]          rec_type;
  logic                rec_vis;
  logic [15:0]         sh_valid;
  logic [8:0]          sh_x [16];
  logic [7:0]          sh_y [16];
  logic                erase_hit, go, scan_last, in_erase;
  logic [COLOUR_W-1:0] type_col, go_col;
  logic                unused_bits;

  assign unused_bits = ^{ram_data[22:19], ram_data[10:4], ram_data[0]};

  always_comb begin
    type_col = COL_DIAMOND;  // types 2 and 3 share a colour
    case (rec_type)
      TYPE_STONE: type_col = COL_STONE;
      TYPE_GOLD:  type_col = COL_GOLD;
      default:    type_col = COL_DIAMOND;
    endcase
    erase_hit = sh_valid[draw_index] &&
                (!rec_vis || rec_x != sh_x[draw_index] || rec_y != sh_y[draw_index]);
    go     = (state == E_DECIDE && erase_hit) || (state == D_DECIDE && rec_vis);
    go_x   = (state == E_DECIDE) ? sh_x[draw_index] : rec_x;
    go_y   = (state == E_DECIDE) ? sh_y[draw_index] : rec_y;
    go_col = (state == E_DECIDE) ? COL_BG : type_col;
    // where to go once the current record is finished
    in_erase = (state == E_DECIDE) || (state == E_PIX);
    if (draw_index == qty - 4'd1) begin
      adv_idx   = '0;
      adv_state = in_erase ? D_ADDR : FIN;
    end else begin
      adv_idx   = draw_index + 4'd1;
      adv_state = in_erase ? E_ADDR : D_ADDR;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE; qty <= '0; wait_cnt <= '0; draw_index <= '0;
      busy <= 1'b0; draw_stone_flag <= 1'b0; done <= 1'b0;
      rec_x <= '0; rec_y <= '0; rec_type <= '0; rec_vis <= 1'b0;
      sh_valid <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1; draw_stone_flag <= 1'b1;
          draw_index <= '0; qty <= quantity;
          state <= (quantity == 4'd0) ? FIN : E_ADDR;
        end
        E_ADDR, D_ADDR: begin
          wait_cnt <= '0;
          state <= (state == E_ADDR) ? E_WAIT : D_WAIT;
        end
        E_WAIT, D_WAIT: begin
          if (wait_cnt == WAIT_W'(READ_LATENCY - 1)) begin
            rec_x    <= ram_data[REC_X_LSB +: 9];
            rec_y    <= ram_data[REC_Y_LSB +: 8];
            rec_type <= ram_data[REC_TYPE_LSB +: 2];
            rec_vis  <= ram_data[REC_VIS_BIT];
            state <= (state == E_WAIT) ? E_DECIDE : D_DECIDE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        E_DECIDE: begin
          if (erase_hit) state <= E_PIX;
          else begin state <= adv_state; draw_index <= adv_idx; end
        end
        D_DECIDE: begin
          sh_valid[draw_index] <= rec_vis;
          if (rec_vis) begin
            sh_x[draw_index] <= rec_x;
            sh_y[draw_index] <= rec_y;
            state <= D_PIX;
          end else begin
            state <= adv_state; draw_index <= adv_idx;
          end
        end
        E_PIX, D_PIX: if (scan_last) begin
          state <= adv_state; draw_index <= adv_idx;
        end
        FIN: begin
          done <= 1'b1; busy <= 1'b0; draw_stone_flag <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sprite_scan #(.SPRITE_SIZE(SPRITE_SIZE), .COLOUR_W(COLOUR_W)) u_scan (
    .clock(clock), .resetn(resetn), .go(go),
    .base_x(go_x), .base_y(go_y), .colour_in(go_col),
    .plot(plot), .x_out(x_out), .y_out(y_out), .colour(colour), .last(scan_last)
  );
endmodule

// File: tb/tb_stone_drawer.sv
// Bench for stone_drawer: directed frames plus random item sets, each frame
// checked against an item-level model of erase/draw behaviour.
module tb_stone_drawer;
  localparam int RL = 2;

  logic        clock = 1'b0, resetn = 1'b0, start = 1'b0;
  logic [3:0]  quantity = '0;
  logic [31:0] ram_data;
  logic        draw_stone_flag, plot, busy, done;
  logic [3:0]  draw_index;
  logic [8:0]  x_out;
  logic [7:0]  y_out;
  logic [2:0]  colour;

  stone_drawer dut (
    .clock(clock), .resetn(resetn), .start(start), .quantity(quantity),
    .ram_data(ram_data), .draw_stone_flag(draw_stone_flag),
    .draw_index(draw_index), .plot(plot), .x_out(x_out), .y_out(y_out),
    .colour(colour), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // item RAM with two registered read stages
  logic [31:0] mem [16];
  logic [31:0] p1, p2;
  always @(posedge clock) begin
    p1 <= mem[draw_index];
    p2 <= p1;
  end
  assign ram_data = p2;

  int checks = 0, errors = 0;
  bit m_v [16];
  int m_x [16], m_y [16];
  logic [19:0] exp_q[$], got_q[$];
  int exp_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] mk(input int x, input int y, input int t, input int v, input int g);
    return {9'(x), 4'($urandom), 8'(y), 7'($urandom), 2'(t), 1'(v), 1'(g)};
  endfunction

  function automatic logic [2:0] tcol(input int t);
    return (t == 0) ? 3'b111 : (t == 1) ? 3'b110 : 3'b011;
  endfunction

  task automatic add_square(input int x, input int y, input logic [2:0] c);
    for (int dy = 0; dy < 16; dy++)
      for (int dx = 0; dx < 16; dx++)
        if (x + dx < 320 && y + dy < 240)
          exp_q.push_back({9'(x + dx), 8'(y + dy), c});
  endtask

  task automatic model_frame(input int q);
    exp_q.delete();
    exp_busy = 1;
    for (int i = 0; i < q; i++) begin
      int x, y, v;
      x = int'(mem[i][31:23]); y = int'(mem[i][18:11]); v = int'(mem[i][1]);
      exp_busy += RL + 2;
      if (m_v[i] && (v == 0 || x != m_x[i] || y != m_y[i])) begin
        exp_busy += 256;
        add_square(m_x[i], m_y[i], 3'b000);
      end
    end
    for (int i = 0; i < q; i++) begin
      int x, y, v, t;
      x = int'(mem[i][31:23]); y = int'(mem[i][18:11]);
      v = int'(mem[i][1]); t = int'(mem[i][3:2]);
      exp_busy += RL + 2;
      if (v != 0) begin
        m_v[i] = 1'b1; m_x[i] = x; m_y[i] = y;
        exp_busy += 256;
        add_square(x, y, tcol(t));
      end else begin
        m_v[i] = 1'b0;
      end
    end
  endtask

  function automatic int count_col(input logic [2:0] c);
    int n = 0;
    foreach (got_q[i]) if (got_q[i][2:0] == c) n++;
    return n;
  endfunction

  int flag_n;

  task automatic run_frame(input int q, input bit extra);
    int busy_n, done_n, cyc, bad, idle_bad;
    bit fin;
    quantity = 4'(q);
    model_frame(q);
    got_q.delete();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    chk("hs_busy", busy, 1);
    chk("hs_flag", draw_stone_flag, 1);
    chk("hs_index", draw_index, 0);
    busy_n = 0; flag_n = 0; done_n = 0; cyc = 0; fin = 1'b0;
    while (!fin && cyc < 20000) begin
      if (busy) busy_n++;
      if (draw_stone_flag) flag_n++;
      if (plot) got_q.push_back({x_out, y_out, colour});
      if (done) begin done_n++; fin = 1'b1; end
      start = extra && (cyc == 5);
      if (!fin) begin @(negedge clock); cyc++; end
    end
    start = 1'b0;
    chk("timeout", fin, 1);
    chk("busy_cycles", busy_n, exp_busy);
    chk("flag_cycles", flag_n, exp_busy);
    chk("done_pulses", done_n, 1);
    chk("plot_count", got_q.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad++;
    chk("plot_seq", bad, 0);
    idle_bad = 0;
    repeat (4) begin
      @(negedge clock);
      if (busy || plot || done) idle_bad++;
    end
    chk("idle_after", idle_bad, 0);
  endtask

  initial begin
    int q, n;
    for (int i = 0; i < 16; i++) begin
      mem[i] = mk(i * 20, 10, 0, 0, 0);
      m_v[i] = 1'b0; m_x[i] = 0; m_y[i] = 0;
    end
    repeat (3) @(negedge clock);
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flag", draw_stone_flag, 0);
    chk("rst_done", done, 0);
    chk("rst_pix", {x_out, y_out, colour, draw_index}, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    run_frame(0, 0);
    chk("q0_flag_short", flag_n <= 3, 1);
    chk("q0_plots", got_q.size(), 0);

    mem[0] = mk(100, 50, 1, 1, 0);
    run_frame(1, 0);
    chk("gold_first", got_q[0], {9'd100, 8'd50, 3'b110});
    chk("gold_last", got_q[255], {9'd115, 8'd65, 3'b110});

    run_frame(1, 0);
    chk("same_no_bg", count_col(3'b000), 0);
    chk("same_gold", count_col(3'b110), 256);

    mem[0] = mk(104, 50, 1, 1, 1);
    run_frame(1, 0);
    chk("move_bg", count_col(3'b000), 256);
    chk("move_bg_first", got_q[0], {9'd100, 8'd50, 3'b000});
    chk("move_gold_first", got_q[256], {9'd104, 8'd50, 3'b110});

    mem[0] = mk(310, 230, 2, 1, 0);
    run_frame(1, 0);
    chk("clip_diamond", count_col(3'b011), 100);

    mem[0] = mk(30, 30, 3, 1, 0);
    run_frame(1, 0);
    mem[0] = mk(30, 30, 3, 0, 0);
    run_frame(1, 0);
    chk("vanish_bg", count_col(3'b000), 256);
    chk("vanish_total", got_q.size(), 256);
    run_frame(1, 0);
    chk("vanish_next", got_q.size(), 0);

    for (int f = 0; f < 5; f++) begin
      q = $urandom_range(1, 15);
      for (int i = 0; i < 16; i++)
        if ($urandom_range(0, 2) != 0)
          mem[i] = mk($urandom_range(0, 340), $urandom_range(0, 250),
                      $urandom_range(0, 3), ($urandom_range(0, 3) != 0) ? 1 : 0,
                      $urandom_range(0, 1));
      run_frame(q, q >= 2);
    end

    // reset in the middle of a draw square
    for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
    run_frame(16 - 1, 0);
    mem[0] = mk(40, 40, 0, 1, 0);
    run_frame(1, 0);
    quantity = 4'd1;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    n = 0;
    while (!(plot && colour == 3'b111) && n < 100) begin @(negedge clock); n++; end
    chk("reach_dpix", plot, 1);
    repeat (3) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    chk("mid_rst_plot", plot, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_flag", draw_stone_flag, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_pix", {x_out, y_out, colour, draw_index}, 0);
    resetn = 1'b1;
    for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
    mem[0] = mk(60, 40, 0, 1, 0);
    run_frame(1, 0);
    chk("post_rst_no_bg", count_col(3'b000), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
